// File: rtl/gray_pkg.sv
// ---------------------------------------------------------------------------
// gray_pkg
// Shared definitions for the Gray sweep sequencer and its encoder.
//   sweepState_e : sequencer states (IDLE, RUN, DONE)
//   DIR_UP/DOWN  : encoding of the latched sweep direction
//   bin2gray     : binary-to-Gray conversion for any width up to GRAY_MAX_W.
//                  Callers zero-extend their operand to GRAY_MAX_W and cast
//                  the result back down to their own width.
// ---------------------------------------------------------------------------
package gray_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sweepState_e;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  localparam int GRAY_MAX_W = 32;

  // Zero-extended inputs give zero upper Gray bits, so the low bits of the
  // result are exactly the Gray code of the narrower operand.
  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_enc.sv
// ---------------------------------------------------------------------------
// gray_enc
// Purely combinational WIDTH-bit binary-to-Gray encoder.
//   bin_i  [WIDTH-1:0] : binary value (normally a register output)
//   gray_o [WIDTH-1:0] : bin_i ^ (bin_i >> 1)
// Each output bit depends only on two register bits through a single XOR,
// so the code follows its source with no added state.
// ---------------------------------------------------------------------------
module gray_enc
  import gray_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] bin_i,
  output logic [WIDTH-1:0] gray_o
);

  // Widen to the package function's operand size, convert, and narrow back.
  assign gray_o = WIDTH'(bin2gray(GRAY_MAX_W'(bin_i)));

endmodule

// File: rtl/gray_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// gray_sweep_ctrl
// Steps a binary index from a latched first code to a latched last code,
// one code per accepted valid/ready transfer, presenting each code in both
// binary and Gray form.
//   clk, rst       : clock and synchronous active-high reset
//   start          : begin a sweep (honoured only in IDLE)
//   dir            : 0 = increment, 1 = decrement (latched at start)
//   first, last    : sweep bounds (latched at start)
//   abort          : drop the running sweep without a done pulse
//   out_ready      : downstream accepts the presented code
//   out_valid      : out_bin/out_gray hold a valid code
//   out_bin        : current binary index
//   out_gray       : Gray code of out_bin
//   busy           : sweep in progress
//   done           : one-cycle pulse after the last code was accepted
//   count          : codes accepted in the current or most recent sweep
// ---------------------------------------------------------------------------
module gray_sweep_ctrl
  import gray_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             dir,
  input  logic [WIDTH-1:0] first,
  input  logic [WIDTH-1:0] last,
  input  logic             abort,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_bin,
  output logic [WIDTH-1:0] out_gray,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   count
);

  localparam logic [WIDTH-1:0] BIN_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH:0]   CNT_ONE = {{WIDTH{1'b0}}, 1'b1};

  sweepState_e      state_q, state_d;
  logic [WIDTH-1:0] outBin_q, outBin_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic             dir_q, dir_d;
  logic [WIDTH:0]   count_q, count_d;
  logic             xfer;

  // A transfer can only happen in RUN, where out_valid is high by
  // construction, so the handshake reduces to state plus out_ready.
  assign xfer = (state_q == RUN) && out_ready;

  // State register. Everything, including the latched bounds, goes back to
  // zero on reset; reset outranks every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      outBin_q <= '0;
      last_q   <= '0;
      dir_q    <= DIR_UP;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      outBin_q <= outBin_d;
      last_q   <= last_d;
      dir_q    <= dir_d;
      count_q  <= count_d;
    end
  end

  // Next-state and datapath logic. The first bound is not kept separately:
  // it is loaded straight into the index register at start. In RUN, abort
  // is checked before the handshake so an aborted transfer is never
  // counted. Reaching the last code leaves out_bin holding it, which is what
  // DONE and the following IDLE present.
  always_comb begin
    state_d  = state_q;
    outBin_d = outBin_q;
    last_d   = last_q;
    dir_d    = dir_q;
    count_d  = count_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          outBin_d = first;
          last_d   = last;
          dir_d    = dir;
          count_d  = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (xfer) begin
          count_d = count_q + CNT_ONE;
          if (outBin_q == last_q) begin
            state_d = DONE;
          end else if (dir_q == DIR_UP) begin
            outBin_d = outBin_q + BIN_ONE;
          end else begin
            outBin_d = outBin_q - BIN_ONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode. Every status output comes from the state register alone,
  // so out_valid has no combinational path from out_ready.
  always_comb begin
    out_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      RUN:     begin out_valid = 1'b1; busy = 1'b1; end
      DONE:    done = 1'b1;
      default: ;
    endcase
    out_bin = outBin_q;
    count   = count_q;
  end

  // Gray view of the index register.
  gray_enc #(
    .WIDTH (WIDTH)
  ) uGrayEnc (
    .bin_i  (outBin_q),
    .gray_o (out_gray)
  );

endmodule
